// File: rtl/intersection_scheduler.sv
// Two-approach intersection controller: sequences NS/EW lamps with yellow and all-red
// clearance, pedestrian-driven green truncation, rest-in-green and emergency preemption.
module intersection_scheduler #(
    parameter int GREEN_T   = 60,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int MIN_GREEN = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_ns,
    input  logic       ped_ew,
    input  logic       preempt,
    input  logic       preempt_dir,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [7:0] remaining,
    output logic [2:0] phase
);

    localparam logic [2:0] INIT_AR = 3'd0;
    localparam logic [2:0] NS_G    = 3'd1;
    localparam logic [2:0] NS_Y    = 3'd2;
    localparam logic [2:0] NS_AR   = 3'd3;
    localparam logic [2:0] EW_G    = 3'd4;
    localparam logic [2:0] EW_Y    = 3'd5;
    localparam logic [2:0] EW_AR   = 3'd6;

    localparam logic [7:0] GREEN_LD  = 8'(GREEN_T - 1);
    localparam logic [7:0] YELLOW_LD = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_LD = 8'(ALLRED_T - 1);
    localparam logic [7:0] TRUNC_LD  = 8'(MIN_GREEN - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       latch_ns_q, latch_ns_d;
    logic       latch_ew_q, latch_ew_d;
    logic       walk_ns_q, walk_ns_d;
    logic       walk_ew_q, walk_ew_d;

    // A button pressed this cycle counts as already latched.
    logic pend_ns, pend_ew;
    logic own_pre, other_pre, cross_dem, cross_ped;
    logic [2:0] yellow_next;

    assign pend_ns = latch_ns_q | ped_ns;
    assign pend_ew = latch_ew_q | ped_ew;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        latch_ns_d  = pend_ns;
        latch_ew_d  = pend_ew;
        own_pre     = preempt & ~preempt_dir;
        other_pre   = preempt & preempt_dir;
        cross_dem   = req_ew | pend_ew;
        cross_ped   = pend_ew;
        yellow_next = NS_Y;
        if (state_q == EW_G) begin
            own_pre     = preempt & preempt_dir;
            other_pre   = preempt & ~preempt_dir;
            cross_dem   = req_ns | pend_ns;
            cross_ped   = pend_ns;
            yellow_next = EW_Y;
        end

        case (state_q)
            INIT_AR, EW_AR: begin
                if (count_q == 8'd0) begin
                    state_d = NS_G;
                    count_d = GREEN_LD;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            NS_G, EW_G: begin
                // Preemption outranks rest, which outranks truncation, which outranks decrement.
                if (own_pre) begin
                    count_d = count_q;
                end else if (other_pre || (count_q == 8'd0 && cross_dem)) begin
                    state_d = yellow_next;
                    count_d = YELLOW_LD;
                end else if (count_q == 8'd0) begin
                    count_d = 8'd0;
                end else if (cross_ped && count_q > TRUNC_LD) begin
                    count_d = TRUNC_LD;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            NS_Y, EW_Y: begin
                if (count_q == 8'd0) begin
                    state_d = (state_q == NS_Y) ? NS_AR : EW_AR;
                    count_d = ALLRED_LD;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            NS_AR: begin
                if (count_q == 8'd0) begin
                    state_d = EW_G;
                    count_d = GREEN_LD;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            default: begin
                state_d = INIT_AR;
                count_d = ALLRED_LD;
            end
        endcase

        // On green entry the latch clears and its value becomes the walk grant for that dwell.
        walk_ns_d = 1'b0;
        walk_ew_d = 1'b0;
        if (state_d == NS_G) begin
            walk_ns_d = (state_q == NS_G) ? walk_ns_q : pend_ns;
            if (state_q != NS_G) latch_ns_d = 1'b0;
        end
        if (state_d == EW_G) begin
            walk_ew_d = (state_q == EW_G) ? walk_ew_q : pend_ew;
            if (state_q != EW_G) latch_ew_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together
    // from pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= INIT_AR;
            count_q    <= ALLRED_LD;
            latch_ns_q <= 1'b0;
            latch_ew_q <= 1'b0;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            latch_ns_q <= latch_ns_d;
            latch_ew_q <= latch_ew_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
        end
    end

    assign ns_green  = (state_q == NS_G);
    assign ns_yellow = (state_q == NS_Y);
    assign ns_red    = ~(ns_green | ns_yellow);
    assign ew_green  = (state_q == EW_G);
    assign ew_yellow = (state_q == EW_Y);
    assign ew_red    = ~(ew_green | ew_yellow);
    assign walk_ns   = walk_ns_q;
    assign walk_ew   = walk_ew_q;
    assign remaining = count_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: the driver queues hand-computed per-cycle
// expectations, and a negedge monitor pops and compares them alongside lamp-safety checks.
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, req_ns, req_ew, ped_ns, ped_ew, preempt, preempt_dir;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       walk_ns, walk_ew;
    logic [7:0] remaining;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] ph;
        logic [7:0] rem;
        logic       wns;
        logic       wew;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    intersection_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_ns(req_ns), .req_ew(req_ew), .ped_ns(ped_ns), .ped_ew(ped_ew),
        .preempt(preempt), .preempt_dir(preempt_dir),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk_ns(walk_ns), .walk_ew(walk_ew),
        .remaining(remaining), .phase(phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g} for a phase value.
    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd1:    return 6'b001_100;
            3'd2:    return 6'b010_100;
            3'd4:    return 6'b100_001;
            3'd5:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    always @(negedge clk) begin
        n_vec++;
        if (!$onehot({ns_red, ns_yellow, ns_green}) || !$onehot({ew_red, ew_yellow, ew_green}) ||
            (!ns_red && !ew_red)) begin
            n_err++;
            $display("FAIL lamp_safety cyc=%0d: got ns=%b%b%b ew=%b%b%b, want one-hot and one side red",
                     cyc, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", mon_e.name, mon_e.cyc, cyc);
            end else if (phase !== mon_e.ph || remaining !== mon_e.rem || walk_ns !== mon_e.wns ||
                         walk_ew !== mon_e.wew ||
                         {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} !== lamps_for(mon_e.ph)) begin
                n_err++;
                $display("FAIL %s cyc=%0d: got phase=%0d rem=%0d walk_ns=%b walk_ew=%b lamps=%b, want phase=%0d rem=%0d walk_ns=%b walk_ew=%b lamps=%b",
                         mon_e.name, cyc, phase, remaining, walk_ns, walk_ew,
                         {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green},
                         mon_e.ph, mon_e.rem, mon_e.wns, mon_e.wew, lamps_for(mon_e.ph));
            end
        end
    end

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input logic [2:0] ph, input int rem, input logic wns, input logic wew,
                        input string name);
        exp_t e;
        e.cyc  = cyc;
        e.ph   = ph;
        e.rem  = 8'(rem);
        e.wns  = wns;
        e.wew  = wew;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [2:0] ph, input int from, input int to, input logic wns,
                         input logic wew, input string name);
        for (int r = from; r >= to; r--) step(ph, r, wns, wew, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req_ns = 1'b0; req_ew = 1'b1; ped_ns = 1'b0; ped_ew = 1'b0;
        preempt = 1'b0; preempt_dir = 1'b0;
        @(posedge clk);
        #1;

        // Reset and full NS cycle with EW demand held.
        step(0, 1, 0, 0, "reset_hold");
        step(0, 1, 0, 0, "reset_hold");
        rst_n = 1'b0;
        step(0, 1, 0, 0, "release");
        step(0, 0, 0, 0, "init_ar");
        dwell(1, 59, 0, 0, 0, "ns_g");
        dwell(2, 4, 0, 0, 0, "ns_y");
        dwell(3, 1, 0, 0, 0, "ns_ar");

        // Rest in EW green with no demand, then NS demand releases it.
        req_ew = 1'b0;
        dwell(4, 59, 0, 0, 0, "ew_g");
        repeat (4) step(4, 0, 0, 0, "ew_rest");
        req_ns = 1'b1;
        step(4, 0, 0, 0, "ew_rest_exit");
        dwell(5, 4, 0, 0, 0, "ew_y");
        dwell(6, 1, 0, 0, 0, "ew_ar");

        // Rest in NS green; single-cycle EW request ends it next cycle.
        req_ns = 1'b0;
        dwell(1, 59, 0, 0, 0, "ns_g2");
        repeat (4) step(4'(1), 0, 0, 0, "ns_rest");
        req_ew = 1'b1;
        step(1, 0, 0, 0, "ns_rest_pulse");
        req_ew = 1'b0;
        dwell(2, 4, 0, 0, 0, "ns_y_after_pulse");
        dwell(3, 1, 0, 0, 0, "ns_ar2");
        req_ns = 1'b1;
        dwell(4, 59, 0, 0, 0, "ew_g2");
        dwell(5, 4, 0, 0, 0, "ew_y2");
        dwell(6, 1, 0, 0, 0, "ew_ar2");

        // EW pedestrian truncates NS green and earns walk for the next EW green.
        req_ew = 1'b1;
        dwell(1, 59, 41, 0, 0, "ns_g3");
        ped_ew = 1'b1;
        step(1, 40, 0, 0, "ped_ew_press");
        ped_ew = 1'b0;
        dwell(1, 9, 0, 0, 0, "ns_truncated");
        dwell(2, 4, 0, 0, 0, "ns_y3");
        dwell(3, 1, 0, 0, 0, "ns_ar3");
        dwell(4, 59, 0, 0, 1, "ew_walk");
        dwell(5, 4, 0, 0, 0, "ew_y3");
        dwell(6, 1, 0, 0, 0, "ew_ar3");

        // Preemption toward EW from mid NS green.
        dwell(1, 59, 31, 0, 0, "ns_g4");
        preempt = 1'b1;
        preempt_dir = 1'b1;
        step(1, 30, 0, 0, "preempt_hit");
        dwell(2, 4, 0, 0, 0, "preempt_ns_y");
        dwell(3, 1, 0, 0, 0, "preempt_ns_ar");
        repeat (6) step(4, 59, 0, 0, "ew_frozen");
        preempt = 1'b0;
        step(4, 59, 0, 0, "preempt_release");
        dwell(4, 58, 0, 0, 0, "ew_resume");

        // Asynchronous reset during EW yellow, with an NS pedestrian latch pending.
        ped_ns = 1'b1;
        step(5, 4, 0, 0, "ew_y4");
        ped_ns = 1'b0;
        step(5, 3, 0, 0, "ew_y4");
        rst_n = 1'b1;
        step(0, 1, 0, 0, "async_reset");
        step(0, 1, 0, 0, "reset_hold2");
        rst_n = 1'b0;
        step(0, 1, 0, 0, "release2");
        step(0, 0, 0, 0, "init_ar2");
        dwell(1, 59, 55, 0, 0, "ns_after_reset");

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Two-approach intersection controller that sequences the red/yellow/green lamp sets of the north-south (NS) and east-west (EW) approaches. It enforces yellow and all-red clearance between conflicting greens and alternates service between approaches. Green time is shortened by cross-street pedestrian demand, and the block holds green when the cross street is idle. It sits above the per-approach lamp drivers and also supplies the countdown value for the display.

## Interface
Parameters:
- GREEN_T, 60: green dwell in cycles (≥ MIN_GREEN+1, ≤ 255)
- YELLOW_T, 5: yellow dwell in cycles (≥ 1)
- ALLRED_T, 2: all-red clearance in cycles (≥ 1)
- MIN_GREEN, 10: green remaining cap applied on cross pedestrian demand (≥ 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets)
- req_ns, req_ew  in  1 each  vehicle detector demand, level
- ped_ns, ped_ew  in  1 each  pedestrian button, single-cycle pulse or level
- preempt  in  1  emergency preemption, level
- preempt_dir  in  1  preemption target: 0=NS, 1=EW
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps, one-hot
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps, one-hot
- walk_ns, walk_ew  out  1 each  pedestrian walk indication
- remaining  out  8  cycles left in current state (count register)
- phase  out  3  current state encoding

## Operation
States, with their phase encoding:
- INIT_AR=0: entered only from reset.
- NS_G=1, NS_Y=2, NS_AR=3.
- EW_G=4, EW_Y=5, EW_AR=6.

Transitions:
- INIT_AR→NS_G, NS_G→NS_Y→NS_AR→EW_G, EW_G→EW_Y→EW_AR→NS_G. No other transitions.

Count register:
- On state entry, loaded with dwell-1 (GREEN_T-1, YELLOW_T-1 or ALLRED_T-1).
- Decrements by 1 per cycle.
- A state exits on the cycle after count==0 is observed, so every dwell is exactly its parameter value in cycles.

Cross demand:
- Defined as req_other | ped_latch_other.

Rest in green:
- In X_G with count==0 and no cross demand, the state holds with count held at 0.
- The state exits the cycle after cross demand appears.

Pedestrian latches (ped_latch_ns, ped_latch_ew):
- Set on any cycle the corresponding button is 1.
- Cleared on entry to that approach's green.
- Set and clear in the same cycle: clear wins, and the walk is granted for this green.
- walk_X=1 for the whole X_G dwell when ped_latch_X was set on the entry cycle. Otherwise walk_X=0.
- walk_X is 0 in all non-green states.

Truncation:
- In X_G, if ped_latch_other=1 and count > MIN_GREEN-1, count loads MIN_GREEN-1 instead of decrementing.
- Yellow and all-red are never truncated.

Preemption (preempt=1):
- In the target green: count frozen and the state holds; rest-in-green and truncation are suppressed.
- In the conflicting green: go to that approach's yellow next cycle, regardless of count.
- In yellow or all-red: proceed normally. The sequence then reaches the target green, because alternation always leads there from the conflicting side.
- On preempt falling: normal counting resumes from the frozen count.

Lamp outputs:
- Combinational decode of the state register.
- Exactly one lamp per approach is lit.
- At most one approach is non-red at any cycle.

## Timing
Reset (rst_n=1, any time, including mid-sequence):
- state=INIT_AR, count=ALLRED_T-1.
- ns_red=ew_red=1, all yellow/green=0, walk_*=0, latches cleared, remaining=ALLRED_T-1, phase=0.

After reset release:
- First NS_G lamp at cycle ALLRED_T, counting the first clock edge after release as cycle 1.

Latencies:
- Button-to-latch: 1 cycle.
- Latch-to-truncation: same cycle as the latch is visible.
- preempt to yellow in the conflicting green: 1 cycle.
- Lamps and remaining change on the same edge as the state.

Guaranteed sequence:
- Clearance between conflicting greens is YELLOW_T + ALLRED_T cycles, with no exceptions (including preemption).

Width rules:
- count is 8 bits unsigned and never wraps.
- Decrement is suppressed at 0.

Simultaneous events:
- Preempt overrides truncation and rest.
- Truncation overrides normal decrement.

## Test plan
- Reset, then idle inputs with req_ew=1 held: NS_G lasts 60 cycles, NS_Y 5, NS_AR 2, then EW_G. remaining counts 59→0 in NS_G.
- All requests 0 after the first NS_G: NS_G holds at remaining=0 indefinitely. A req_ew pulse causes NS_Y on the next cycle.
- ped_ew pulse at NS_G remaining=40: remaining becomes 9 next cycle, then NS_Y after 10 more cycles. walk_ew=1 for all 60 cycles of the following EW_G.
- preempt=1, preempt_dir=1 at NS_G remaining=30: NS_Y next cycle, then 5 yellow, 2 all-red, then EW_G frozen at remaining=59 while preempt is held. Release: countdown resumes from 59.
- rst_n pulsed high during EW_Y: all lamps red and phase=0 immediately (asynchronous). Latches cleared, and NS_G follows ALLRED_T cycles after release.
- Continuous check over all scenarios: never both approaches non-red, and each approach's lamps are one-hot.
